// File: rtl/sprite_scene_ctrl.sv
// Sprite scene controller: debounced button drives a HOME/OPENING/DOOR/CLOSING slide, updated once per frame.
// Optional macro SCENE_DEBOUNCE_EN enables the multi-frame button debounce; otherwise the synchronized press is used directly.
module sprite_scene_ctrl #(
  parameter int STEP        = 8,
  parameter int DB_FRAMES   = 3,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       select_n,
  input  logic       puerta,
  output logic [9:0] pos_x0,
  output logic [9:0] pos_x1,
  output logic [9:0] pos_x2,
  output logic [9:0] pos_x3,
  output logic [9:0] pos_y0,
  output logic [9:0] pos_y1,
  output logic [9:0] pos_y2,
  output logic [9:0] pos_y3,
  output logic [1:0] scene,
  output logic       frame_start
);

  typedef enum logic [1:0] {HOME = 2'd0, OPENING = 2'd1, DOOR = 2'd2, CLOSING = 2'd3} scene_t;

  localparam logic [9:0] HOME_X  = 10'd270;
  localparam logic [9:0] HOME_Y  = 10'd190;
  localparam logic [9:0] PARK_X  = 10'd0;
  localparam logic [9:0] PARK_Y  = 10'd490;
  localparam logic [9:0] FLOOR_Y = 10'd480;
  localparam int         RW      = $clog2(HOLD_FRAMES + 1);

  scene_t     state_q, state_d;
  logic [9:0] x0_q, y0_q, x3_q, y3_q;
  logic [9:0] x0_d, y0_d, x3_d, y3_d;
  logic [1:0] sel_sync, door_sync;
  logic       press, level_q, level_d, trigger, hold_done;
  logic [RW-1:0] rel_cnt;
  logic [10:0]   y_up, y_dn;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_sync    <= '0;
      door_sync   <= '0;
      frame_start <= 1'b0;
    end else begin
      sel_sync    <= {sel_sync[0], select_n};
      door_sync   <= {door_sync[0], puerta};
      frame_start <= enable && (hcount == 10'd0) && (vcount == 10'd480);
    end
  end

  assign press = ~sel_sync[1] | door_sync[1];

`ifdef SCENE_DEBOUNCE_EN
  localparam int DW = $clog2(DB_FRAMES + 1);
  logic [DW-1:0] db_cnt;

  // Level flips on the DB_FRAMES-th consecutive differing sample.
  assign level_d = (press != level_q && db_cnt == DW'(DB_FRAMES - 1)) ? press : level_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
    end else if (frame_start) begin
      if (press == level_q || level_d != level_q) db_cnt <= '0;
      else                                        db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  assign level_d = press;
`endif

  assign trigger   = frame_start & level_d & ~level_q;
  assign hold_done = (state_q == DOOR) && !level_d && (rel_cnt == RW'(HOLD_FRAMES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      rel_cnt <= '0;
    end else if (frame_start) begin
      level_q <= level_d;
      if (state_q == DOOR && !level_d && !hold_done) rel_cnt <= rel_cnt + 1'b1;
      else                                           rel_cnt <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= HOME;
      x0_q    <= HOME_X;
      y0_q    <= HOME_Y;
      x3_q    <= PARK_X;
      y3_q    <= PARK_Y;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x3_d    = x3_q;
    y3_d    = y3_q;
    y_up    = {1'b0, y0_q} + 11'(STEP);
    y_dn    = {1'b0, y0_q} - 11'(STEP);
    if (frame_start) begin
      case (state_q)
        HOME: if (trigger) state_d = OPENING;
        OPENING: begin
          if (y_up >= {1'b0, FLOOR_Y}) begin
            x0_d    = PARK_X;
            y0_d    = PARK_Y;
            x3_d    = HOME_X;
            y3_d    = HOME_Y;
            state_d = DOOR;
          end else begin
            y0_d = y_up[9:0];
          end
        end
        DOOR: begin
          if (hold_done) begin
            x3_d    = PARK_X;
            y3_d    = PARK_Y;
            x0_d    = HOME_X;
            y0_d    = FLOOR_Y;
            state_d = CLOSING;
          end
        end
        CLOSING: begin
          // A re-press reverses direction and suppresses this frame's step.
          if (trigger) begin
            state_d = OPENING;
          end else if (y_dn[10] || y_dn <= {1'b0, HOME_Y}) begin
            y0_d    = HOME_Y;
            state_d = HOME;
          end else begin
            y0_d = y_dn[9:0];
          end
        end
        default: state_d = HOME;
      endcase
    end
  end

  assign scene  = state_q;
  assign pos_x0 = x0_q;
  assign pos_y0 = y0_q;
  assign pos_x3 = x3_q;
  assign pos_y3 = y3_q;
  assign pos_x1 = 10'd50;
  assign pos_y1 = 10'd220;
  assign pos_x2 = 10'd500;
  assign pos_y2 = 10'd220;

endmodule

// File: tb/tb_sprite_scene_ctrl.sv
// Self-checking bench for sprite_scene_ctrl: table-driven opening sequence plus directed DOOR/CLOSING/reset/glitch cases.
// Expectations adapt to SCENE_DEBOUNCE_EN through the press-to-trigger latency LAT.
module tb_sprite_scene_ctrl;
`ifdef SCENE_DEBOUNCE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       reset, enable, select_n, puerta;
  logic [9:0] hcount, vcount;
  logic [9:0] pos_x0, pos_x1, pos_x2, pos_x3, pos_y0, pos_y1, pos_y2, pos_y3;
  logic [1:0] scene;
  logic       frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  sprite_scene_ctrl dut (
    .clock(clock), .reset(reset), .enable(enable), .hcount(hcount), .vcount(vcount),
    .select_n(select_n), .puerta(puerta),
    .pos_x0(pos_x0), .pos_x1(pos_x1), .pos_x2(pos_x2), .pos_x3(pos_x3),
    .pos_y0(pos_y0), .pos_y1(pos_y1), .pos_y2(pos_y2), .pos_y3(pos_y3),
    .scene(scene), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       puerta;
    logic [1:0] scene;
    logic [9:0] x0, y0, x3, y3;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_sprites(input string tag, input logic [9:0] x0, input logic [9:0] y0,
                               input logic [9:0] x3, input logic [9:0] y3);
    check({tag, "_x0"}, pos_x0, x0);
    check({tag, "_y0"}, pos_y0, y0);
    check({tag, "_x3"}, pos_x3, x3);
    check({tag, "_y3"}, pos_y3, y3);
  endtask

  // One frame: idle ticks at a non-trigger position, then the frame tick; returns after the update edge.
  task automatic frame();
    logic [1:0] s0;
    s0 = scene;
    repeat (4) begin
      @(negedge clock);
      enable = 1'b1; hcount = 10'd7; vcount = 10'd480;
    end
    @(negedge clock);
    check("no_fs_idle", frame_start, 1'b0);
    check("scene_stable", scene, s0);
    enable = 1'b1; hcount = 10'd0; vcount = 10'd480;
    @(negedge clock);
    enable = 1'b0;
    check("fs_pulse", frame_start, 1'b1);
    @(negedge clock);
    check("fs_single", frame_start, 1'b0);
  endtask

  task automatic frames_expect(input int n, input logic [1:0] sc, input string tag);
    for (int i = 0; i < n; i++) begin
      frame();
      check(tag, scene, sc);
    end
  endtask

  initial begin
    // Opening table: 2 idle frames, then puerta held through the whole slide into DOOR.
    for (int i = 0; i < LAT + 39; i++) begin
      vec_t v;
      int   s;
      v.puerta = (i >= 2);
      v.x0 = 10'd270; v.y0 = 10'd190; v.x3 = 10'd0; v.y3 = 10'd490;
      s = i - (LAT + 1);
      if (s < 0) begin
        v.scene = 2'd0;
      end else if (s < 37) begin
        v.scene = 2'd1;
        v.y0    = 10'(190 + 8 * s);
      end else begin
        v.scene = 2'd2;
        v.x0 = 10'd0; v.y0 = 10'd490; v.x3 = 10'd270; v.y3 = 10'd190;
      end
      tbl.push_back(v);
    end

    reset = 1'b1; enable = 1'b0; hcount = '0; vcount = '0; select_n = 1'b1; puerta = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_scene", scene, 2'd0);
    check("rst_fs", frame_start, 1'b0);
    check_sprites("rst", 10'd270, 10'd190, 10'd0, 10'd490);
    check("rst_x1", pos_x1, 10'd50);
    check("rst_y1", pos_y1, 10'd220);
    check("rst_x2", pos_x2, 10'd500);
    check("rst_y2", pos_y2, 10'd220);
    reset = 1'b0;

    foreach (tbl[i]) begin
      puerta = tbl[i].puerta;
      frame();
      check($sformatf("tbl%0d_scene", i), scene, tbl[i].scene);
      check_sprites($sformatf("tbl%0d", i), tbl[i].x0, tbl[i].y0, tbl[i].x3, tbl[i].y3);
    end

    // DOOR: partial release, re-press clears the hold counter, then a full hold closes.
    puerta = 1'b0;
    frames_expect(30, 2'd2, "door_rel1");
    puerta = 1'b1;
    frames_expect(LAT, 2'd2, "door_press");
    puerta = 1'b0;
    frames_expect(59 + LAT - 1, 2'd2, "door_hold");
    frame();
    check("close_scene", scene, 2'd3);
    check_sprites("close", 10'd270, 10'd480, 10'd0, 10'd490);

    // CLOSING: step down to 400, then the trigger frame reverses without stepping.
    for (int j = 1; j <= 10; j++) begin
      puerta = (j > 11 - LAT);
      frame();
      check($sformatf("cl_step%0d_y0", j), pos_y0, 10'(480 - 8 * j));
      check("cl_step_scene", scene, 2'd3);
    end
    puerta = 1'b1;
    frame();
    check("rev_scene", scene, 2'd1);
    check("rev_y0_kept", pos_y0, 10'd400);

    // Reopening lands exactly on 480 -> DOOR.
    for (int k = 1; k <= 9; k++) begin
      frame();
      check($sformatf("reop%0d_y0", k), pos_y0, 10'(400 + 8 * k));
      check("reop_scene", scene, 2'd1);
    end
    frame();
    check("door2_scene", scene, 2'd2);
    check_sprites("door2", 10'd0, 10'd490, 10'd270, 10'd190);

    puerta = 1'b0;
    frames_expect(59 + LAT - 1, 2'd2, "door2_hold");
    frame();
    check("close2_scene", scene, 2'd3);
    check("close2_y0", pos_y0, 10'd480);

    // Full close: 192 after 36 steps, then 184 clamps to 190 and returns HOME.
    for (int j = 1; j <= 36; j++) begin
      frame();
      check($sformatf("cl2_step%0d_y0", j), pos_y0, 10'(480 - 8 * j));
    end
    check("cl2_scene", scene, 2'd3);
    frame();
    check("home_scene", scene, 2'd0);
    check_sprites("home", 10'd270, 10'd190, 10'd0, 10'd490);

    // select_n alone opens the scene.
    select_n = 1'b0;
    frames_expect(LAT - 1, 2'd0, "sel_wait");
    frame();
    check("sel_open", scene, 2'd1);
    check("sel_y0", pos_y0, 10'd190);
    for (int k = 1; k <= 3; k++) frame();
    check("sel_y0_214", pos_y0, 10'd214);

    // Asynchronous reset mid-slide, away from any clock edge.
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_scene", scene, 2'd0);
    check_sprites("arst", 10'd270, 10'd190, 10'd0, 10'd490);
    check("arst_fs", frame_start, 1'b0);
    select_n = 1'b1;
    @(negedge clock);
    enable = 1'b1; hcount = 10'd0; vcount = 10'd480;
    @(negedge clock);
    enable = 1'b0;
    check("rst_fs_blocked", frame_start, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    enable = 1'b0; hcount = 10'd0; vcount = 10'd480;
    @(negedge clock);
    check("no_fs_wo_enable", frame_start, 1'b0);

    // Two-frame glitch: filtered with debounce, opens immediately without.
    puerta = 1'b1;
    frame();
    frame();
    puerta = 1'b0;
    frame();
    frame();
    check("glitch_scene", scene, (LAT == 3) ? 2'd0 : 2'd1);
    check("glitch_y0", pos_y0, (LAT == 3) ? 10'd190 : 10'd214);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_scene_ctrl.md
SPRITE_SCENE_CTRL -- requirements
Module: sprite_scene_ctrl

Interface
REQ-001 Parameter STEP, default 8, pixels moved per frame while sliding.
REQ-002 Parameter DB_FRAMES, default 3, consecutive frame samples required for a debounced button change.
REQ-003 Parameter HOLD_FRAMES, default 60, frames of button release required in DOOR before closing.
REQ-004 Port clock, input, 1, system clock; the only clock.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port enable, input, 1, pixel tick, one clock wide, every 4th clock.
REQ-007 Port hcount, input, 10, current horizontal pixel count (0..799).
REQ-008 Port vcount, input, 10, current line count (0..524).
REQ-009 Port select_n, input, 1, raw select button, active-low, asynchronous.
REQ-010 Port puerta, input, 1, raw door button, active-high, asynchronous.
REQ-011 Ports pos_x0..pos_x3, outputs, 10 each, sprite 0..3 horizontal origin.
REQ-012 Ports pos_y0..pos_y3, outputs, 10 each, sprite 0..3 vertical origin.
REQ-013 Port scene, output, 2, current state: 0 HOME, 1 OPENING, 2 DOOR, 3 CLOSING.
REQ-014 Port frame_start, output, 1, registered one-clock pulse marking position update.

Function
REQ-015 frame_start SHALL pulse one clock after the clock where enable=1, hcount=0, vcount=480.
REQ-016 select_n and puerta SHALL each pass a 2-flop synchronizer; press = ~select_n_sync | puerta_sync.
REQ-017 press SHALL be sampled only on frame_start; the debounced level changes after DB_FRAMES consecutive equal samples differing from it.
REQ-018 trigger SHALL be the debounced rising edge, one frame_start long.
REQ-019 All position and scene outputs SHALL change only on the clock of a frame_start pulse (tear-free).
REQ-020 Sprite 1 fixed (50,220); sprite 2 fixed (500,220) in all states.
REQ-021 Parked position SHALL be (0,490).
REQ-022 HOME: sprite0 (270,190), sprite3 parked; trigger -> OPENING.
REQ-023 OPENING: per frame pos_y0 += STEP; if new value >= 480, sprite0 parked, sprite3 (270,190), -> DOOR; triggers ignored.
REQ-024 DOOR: release counter counts frames with debounced level 0, clears on level 1; reaching HOLD_FRAMES -> CLOSING with sprite3 parked, sprite0 (270,480).
REQ-025 CLOSING: per frame pos_y0 -= STEP; if new value <= 190, pos_y0=190 -> HOME.
REQ-026 CLOSING with trigger on the same frame as a step SHALL take OPENING and NOT apply the decrement; pos_y0 kept.
REQ-027 Arithmetic 10-bit; compares done on 11-bit sum/difference so no wrap.
REQ-028 No overlap: at most one of sprite0, sprite3 unparked at any time.

Reset
REQ-029 On reset: scene=0, sprite0 (270,190), sprite1 (50,220), sprite2 (500,220), sprite3 (0,490), frame_start=0, synchronizers, debounce and release counters 0.
REQ-030 Reset mid-slide SHALL return immediately to reset values; no partial motion retained.

Configuration
REQ-031 Macro SCENE_DEBOUNCE_EN defined: debounce per REQ-017.
REQ-032 Macro SCENE_DEBOUNCE_EN undefined: debounced level = synchronized press sampled on frame_start (DB_FRAMES unused); all else identical.

Verification
REQ-033 Reset, 2 frames idle -> scene=0, pos_y0=190, pos_x3=0, pos_y3=490.
REQ-034 puerta=1 held 4 frames (debounce on) -> OPENING after 3rd sample; pos_y0 190,198,...; 37th step gives 486 -> DOOR, sprite3 (270,190), sprite0 (0,490).
REQ-035 In DOOR, release 59 frames, press 1 frame, release 60 frames -> CLOSING only after final 60th (plus debounce); pos_y0=480 then 472...
REQ-036 In CLOSING at pos_y0=400, trigger -> OPENING, pos_y0 stays 400 that frame, then 408.
REQ-037 puerta 2-frame glitch, debounce on -> no state change; macro undefined -> OPENING.
REQ-038 Assert reset mid-OPENING at pos_y0=300 -> all outputs per REQ-029 asynchronously; frame_start never pulses without enable.
